// File: rtl/cpu_ctrl.sv
// Instruction-cycle sequencer for the 8-bit accumulator CPU: steps 8 phases
// and decodes opcode/zero into datapath strobes. Strobes are combinational from state.
module cpu_ctrl #(
  parameter int PHASE_W    = 3,
  parameter bit HLT_RESUME = 1'b0
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [2:0]         opcode,
  input  logic               zero,
  input  logic               go,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               wr,
  output logic               data_e,
  output logic               halt,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // HALTED low bits equal 4 so the phase output holds 4 without extra logic.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd12
  } state_t;

  state_t r_state;
  logic   w_aluop;

  assign w_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
  assign phase   = r_state[PHASE_W-1:0];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= INST_ADDR;
    end else begin
      case (r_state)
        INST_ADDR:  r_state <= INST_FETCH;
        INST_FETCH: r_state <= INST_LOAD;
        INST_LOAD:  r_state <= IDLE;
        IDLE:       r_state <= OP_ADDR;
        OP_ADDR:    r_state <= (opcode == OP_HLT) ? HALTED : OP_FETCH;
        OP_FETCH:   r_state <= ALU_OP;
        ALU_OP:     r_state <= STORE;
        STORE:      r_state <= INST_ADDR;
        HALTED:     r_state <= (HLT_RESUME && go) ? INST_ADDR : HALTED;
        default:    r_state <= INST_ADDR;
      endcase
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    case (r_state)
      INST_ADDR:  sel = 1'b1;
      INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
      INST_LOAD,
      IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
      OP_ADDR:    begin inc_pc = 1'b1; halt = (opcode == OP_HLT); end
      OP_FETCH:   rd = w_aluop;
      ALU_OP: begin
        rd     = w_aluop;
        inc_pc = (opcode == OP_SKZ) && zero;
        ld_pc  = (opcode == OP_JMP);
        data_e = (opcode == OP_STO);
      end
      STORE: begin
        rd     = w_aluop;
        ld_ac  = w_aluop;
        ld_pc  = (opcode == OP_JMP);
        inc_pc = (opcode == OP_JMP);
        wr     = (opcode == OP_STO);
        data_e = (opcode == OP_STO);
      end
      HALTED:     begin sel = 1'b1; halt = 1'b1; end
      default:    ;
    endcase
  end

endmodule
